// File: rtl/stream_seq_checker_pkg.sv
// Shared definitions for the en/data strobe link: checker state encoding and
// the default widths used by both the sender and the checker.
package stream_pkg;

    localparam int STREAM_DATA_W = 4;
    localparam int STREAM_GAP_W  = 8;
    localparam int STREAM_CNT_W  = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        RESYNC = 2'd2
    } state_t;

endpackage

// File: rtl/stream_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && !(&q))
            q <= q + W'(1);
    end

endmodule

// File: rtl/stream_seq_checker.sv
// Receive-side checker for the en/data strobe link: locks onto an incrementing
// word sequence, flags value and gap errors, keeps saturating statistics.
module stream_seq_checker
    import stream_pkg::*;
#(
    parameter int DATA_W     = STREAM_DATA_W,
    parameter int GAP_W      = STREAM_GAP_W,
    parameter int CNT_W      = STREAM_CNT_W,
    parameter int RESYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    input  logic [GAP_W-1:0]  gap_min,
    input  logic [GAP_W-1:0]  gap_max,
    output logic [DATA_W-1:0] expected,
    output logic              failure,
    output logic              gap_violation,
    output logic              locked,
    output logic [GAP_W-1:0]  last_gap,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count
);

    localparam int RW = $clog2(RESYNC_LEN + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(RESYNC_LEN - 1);

    state_t           state;
    logic [RW-1:0]    run;
    logic [GAP_W-1:0] gap;
    logic             match;
    logic             gap_bad;
    logic             mismatch;

    assign match    = (data == expected);
    assign gap_bad  = (gap < gap_min) || (gap > gap_max);
    assign mismatch = en && (state != HUNT) && !match;

    // Idle cycles since the last strobe; cleared by the strobe itself.
    sat_counter #(.W(GAP_W)) u_gap (
        .clk(clk), .rst(rst), .clr(en), .inc(1'b1), .q(gap)
    );

    sat_counter #(.W(CNT_W)) u_err (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(mismatch), .q(err_count)
    );

    sat_counter #(.W(CNT_W)) u_words (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(en), .q(word_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= HUNT;
            run           <= '0;
            expected      <= '0;
            failure       <= 1'b0;
            gap_violation <= 1'b0;
            locked        <= 1'b0;
            last_gap      <= '0;
        end else begin
            failure       <= 1'b0;
            gap_violation <= 1'b0;
            case (state)
                HUNT: begin
                    if (en) begin
                        expected <= data + DATA_W'(1);
                        state    <= LOCKED;
                        locked   <= 1'b1;
                    end
                end
                LOCKED, RESYNC: begin
                    if (en) begin
                        last_gap      <= gap;
                        gap_violation <= gap_bad;
                        if (match) begin
                            expected <= expected + DATA_W'(1);
                            if (state == RESYNC) begin
                                run <= run + RW'(1);
                                if (run == RUN_LAST) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end
                        end else begin
                            failure  <= 1'b1;
                            expected <= data + DATA_W'(1);
                            run      <= '0;
                            state    <= RESYNC;
                            locked   <= 1'b0;
                        end
                    end else if (&gap) begin
                        // Link lost: silently fall back to hunting.
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
